// File: rtl/dino_pkg.sv
// Shared types and constants for the Dino obstacle field.
package dino_pkg;

  localparam logic [9:0] PARK_POS = 10'h3FF;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OBS_CACTUS_S = 2'b00,
    OBS_CACTUS_L = 2'b01,
    OBS_CACTUS_G = 2'b10,
    OBS_BIRD     = 2'b11
  } obs_type_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dino_lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
module dino_lfsr16
  import dino_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);
  assign q = lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/obstacle_generator.sv
// Two-slot obstacle spawner/mover for the Dino game.
// Speed ramp enabled by defining OBSTACLE_GEN_SPEEDUP_EN.
module obstacle_generator
  import dino_pkg::*;
#(
  parameter int          CONV              = 0,
  parameter int          GEN_LINE          = 250,
  parameter int          MIN_GAP           = 40,
  parameter int          SPEED_INIT        = 1,
  parameter int          SPEED_MAX         = 4,
  parameter int          SPEED_STEP_FRAMES = 512,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            game_run,
  input  logic            crash,
  input  logic            restart,
  output logic [9-CONV:0] obstacle1_pos,
  output logic [9-CONV:0] obstacle2_pos,
  output logic [1:0]      obstacle1_type,
  output logic [1:0]      obstacle2_type,
  output logic [2:0]      speed,
  output logic            spawn_pulse
);

  state_e          state_q, state_d;
  logic [1:0][9:0] pos_q, pos_d;
  logic [1:0][1:0] typ_q, typ_d;
  logic [7:0]      gap_q, gap_d, gap_dec;
  logic [2:0]      speed_q, speed_d;
  logic            spawn_q, spawn_d;
  logic [1:0]      free, sel;
  logic [15:0]     lfsr;
  logic            lfsr_unused;
  logic            clr, step, spawn;

  dino_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:6];

  assign clr  = restart;
  assign step = !restart && (state_q == ST_RUN)
             && !crash && frame_tick;

  assign gap_dec = (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;
  assign spawn   = step && (gap_dec == 8'd0) && (|free);
  // free is sampled pre-move, so a slot parked this tick waits a tick
  assign sel = {free[1] & ~free[0], free[0]} & {2{spawn}};

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (game_run) state_d = ST_RUN;
        ST_RUN:  if (crash) state_d = ST_FROZEN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (clr)        gap_d = 8'(MIN_GAP);
    else if (spawn) gap_d = 8'(MIN_GAP) + {2'b00, lfsr[5:0]};
    else if (step)  gap_d = gap_dec;
  end

  assign spawn_d = spawn;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    logic hit, drop;
    assign free[i] = (pos_q[i] == PARK_POS);
    assign hit     = pos_q[i] <= {7'd0, speed_q};
    assign drop    = free[i] || hit;
    assign pos_d[i] =
      clr      ? PARK_POS :
      !step    ? pos_q[i] :
      sel[i]   ? 10'(GEN_LINE) :
      drop     ? PARK_POS :
                 pos_q[i] - {7'd0, speed_q};
    assign typ_d[i] =
      clr      ? OBS_CACTUS_S :
      !step    ? typ_q[i] :
      sel[i]   ? lfsr[1:0] :
      drop     ? OBS_CACTUS_S :
                 typ_q[i];
  end

`ifdef OBSTACLE_GEN_SPEEDUP_EN
  localparam int FW = $clog2(SPEED_STEP_FRAMES) + 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          wrap;

  assign wrap = (fcnt_q == FW'(SPEED_STEP_FRAMES - 1));

  always_comb begin
    fcnt_d  = fcnt_q;
    speed_d = speed_q;
    if (clr) begin
      fcnt_d  = '0;
      speed_d = 3'(SPEED_INIT);
    end else if (step) begin
      if (wrap) begin
        fcnt_d = '0;
        if (speed_q < 3'(SPEED_MAX))
          speed_d = speed_q + 3'd1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end
`else
  assign speed_d = 3'(SPEED_INIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= {PARK_POS, PARK_POS};
      typ_q   <= '0;
      gap_q   <= 8'(MIN_GAP);
      speed_q <= 3'(SPEED_INIT);
      spawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      typ_q   <= typ_d;
      gap_q   <= gap_d;
      speed_q <= speed_d;
      spawn_q <= spawn_d;
    end
  end

  assign obstacle1_pos  = pos_q[0][9:CONV];
  assign obstacle2_pos  = pos_q[1][9:CONV];
  assign obstacle1_type = typ_q[0];
  assign obstacle2_type = typ_q[1];
  assign speed          = speed_q;
  assign spawn_pulse    = spawn_q;

endmodule

// File: tb/tb_obstacle_generator.sv
// Bench for obstacle_generator: spec model + expected-output queue.
module tb_obstacle_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_tick = 1'b0;
  logic game_run = 1'b0;
  logic crash = 1'b0;
  logic restart = 1'b0;

  logic [9:0] o1p, o2p;
  logic [1:0] o1t, o2t;
  logic [2:0] ospd;
  logic       osp;
  logic [7:0] c1p, c2p;
  logic [1:0] c1t, c2t;
  logic [2:0] cspd;
  logic       csp;

  always #5 clk = ~clk;

  obstacle_generator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .game_run       (game_run),
    .crash          (crash),
    .restart        (restart),
    .obstacle1_pos  (o1p),
    .obstacle2_pos  (o2p),
    .obstacle1_type (o1t),
    .obstacle2_type (o2t),
    .speed          (ospd),
    .spawn_pulse    (osp)
  );

  obstacle_generator #(.CONV(2)) u_conv (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .game_run       (game_run),
    .crash          (crash),
    .restart        (restart),
    .obstacle1_pos  (c1p),
    .obstacle2_pos  (c2p),
    .obstacle1_type (c1t),
    .obstacle2_type (c2t),
    .speed          (cspd),
    .spawn_pulse    (csp)
  );

  typedef struct packed {
    logic [9:0] p1;
    logic [9:0] p2;
    logic [1:0] t1;
    logic [1:0] t2;
    logic [2:0] sp;
    logic       sg;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [1:0] ct1;
    logic [1:0] ct2;
    logic [2:0] csp;
    logic       csg;
  } obs_t;

  obs_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state, spec terms
  logic [15:0] m_lfsr;
  int m_pos[2];
  int m_typ[2];
  int m_gap, m_speed, m_fcnt, m_state;
  bit m_spawn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
    else m_lfsr <= m_lfsr >> 1;
  end

  task automatic model_reset();
    m_pos[0] = 1023; m_pos[1] = 1023;
    m_typ[0] = 0; m_typ[1] = 0;
    m_gap = 40; m_speed = 1; m_fcnt = 0;
    m_state = 0; m_spawn = 0;
  endtask

  task automatic model_step();
    bit f[2];
    int g;
    f[0] = (m_pos[0] == 1023);
    f[1] = (m_pos[1] == 1023);
    for (int i = 0; i < 2; i++) begin
      if (!f[i]) begin
        if (m_pos[i] <= m_speed) begin
          m_pos[i] = 1023; m_typ[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] - m_speed;
        end
      end
    end
    g = (m_gap > 0) ? m_gap - 1 : 0;
    if (g == 0 && (f[0] || f[1])) begin
      int s;
      s = f[0] ? 0 : 1;
      m_pos[s] = 250;
      m_typ[s] = int'(m_lfsr[1:0]);
      g = 40 + int'(m_lfsr[5:0]);
      m_spawn = 1;
    end
    m_gap = g;
`ifdef OBSTACLE_GEN_SPEEDUP_EN
    m_fcnt++;
    if (m_fcnt == 512) begin
      m_fcnt = 0;
      if (m_speed < 4) m_speed++;
    end
`endif
  endtask

  function automatic obs_t model_out();
    obs_t e;
    e.p1 = 10'(m_pos[0]); e.p2 = 10'(m_pos[1]);
    e.t1 = 2'(m_typ[0]);  e.t2 = 2'(m_typ[1]);
    e.sp = 3'(m_speed);   e.sg = m_spawn;
    e.c1 = 8'(m_pos[0] >> 2); e.c2 = 8'(m_pos[1] >> 2);
    e.ct1 = e.t1; e.ct2 = e.t2;
    e.csp = e.sp; e.csg = e.sg;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.p1 = o1p; o.p2 = o2p; o.t1 = o1t; o.t2 = o2t;
    o.sp = ospd; o.sg = osp;
    o.c1 = c1p; o.c2 = c2p; o.ct1 = c1t; o.ct2 = c2t;
    o.csp = cspd; o.csg = csp;
    return o;
  endfunction

  // one clock of stimulus; expected outputs queued for the caller
  task automatic drive_cycle(input bit gr, cr, rs, ft);
    game_run = gr; crash = cr; restart = rs; frame_tick = ft;
    m_spawn = 0;
    if (rs) begin
      model_reset();
    end else begin
      case (m_state)
        0: if (gr) m_state = 1;
        1: if (cr) m_state = 2; else if (ft) model_step();
        default: ;
      endcase
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    frame_tick = 0; crash = 0; restart = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    #1 rst_n = 1'b0;
    #2;
    o = sample();
    checks++;
    if (o.p1 !== 10'h3FF || o.p2 !== 10'h3FF || o.t1 !== 2'b00 ||
        o.t2 !== 2'b00 || o.sp !== 3'd1 || o.sg !== 1'b0 || o.c1 !== 8'hFF) begin
      errors++;
      $display("FAIL reset_state: got %h want p=3ff/3ff t=0 spd=1 sp=0", o);
    end
    model_reset();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_spawn();
    obs_t o, e;
    drive_cycle(1, 0, 0, 0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++; $display("FAIL idle_to_run: got %h want %h", o, e);
    end
    for (int k = 1; k <= 40; k++) begin
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL spawn_walk[%0d]: got %h want %h", k, o, e);
      end
    end
    checks++;
    if (o.p1 !== 10'd250 || o.sg !== 1'b1 || o.c1 !== 8'd62 ||
        o.p2 !== 10'h3FF || o.c2 !== 8'hFF) begin
      errors++;
      $display("FAIL first_spawn: got p1=%0d sp=%b c1=%0d p2=%h c2=%h want 250 1 62 3ff ff",
               o.p1, o.sg, o.c1, o.p2, o.c2);
    end
    drive_cycle(1, 0, 0, 0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.sg !== 1'b0) begin
      errors++; $display("FAIL spawn_pulse_width: got %h want %h", o, e);
    end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL move_walk[%0d]: got %h want %h", k, o, e);
      end
    end
    checks++;
    if (o.p1 !== 10'd240 || o.p2 !== 10'h3FF) begin
      errors++;
      $display("FAIL ten_ticks: got p1=%0d p2=%h want 240 3ff", o.p1, o.p2);
    end
  endtask

  task automatic test_full_field();
    obs_t o, e;
    bit found;
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (m_pos[0] != 1023 && m_pos[0] <= m_speed &&
          m_pos[1] != 1023 && m_gap == 0) begin
        found = 1;
      end else begin
        drive_cycle(1, 0, 0, 1);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++; $display("FAIL field_walk[%0d]: got %h want %h", n, o, e);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL full_field_timeout: got no park with full field, want one within 400 ticks");
    end else begin
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e || o.p1 !== 10'h3FF || o.t1 !== 2'b00 || o.sg !== 1'b0) begin
        errors++; $display("FAIL park_no_spawn: got %h want %h", o, e);
      end
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e || o.p1 !== 10'd250 || o.sg !== 1'b1 || o.p2 === 10'h3FF) begin
        errors++; $display("FAIL late_spawn: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_freeze();
    obs_t o, e;
    int s0, s1;
    s0 = m_pos[0]; s1 = m_pos[1];
    drive_cycle(1, 1, 0, 1);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++; $display("FAIL crash_tick: got %h want %h", o, e);
    end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL frozen_walk[%0d]: got %h want %h", k, o, e);
      end
    end
    checks++;
    if (o.p1 !== 10'(s0) || o.p2 !== 10'(s1) || o.sg !== 1'b0) begin
      errors++;
      $display("FAIL frozen_hold: got %0d/%0d want %0d/%0d", o.p1, o.p2, s0, s1);
    end
    drive_cycle(1, 1, 1, 1);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o.p1 !== 10'h3FF || o.p2 !== 10'h3FF || o.sp !== 3'd1) begin
      errors++; $display("FAIL crash_restart: got %h want %h", o, e);
    end
  endtask

  task automatic test_speed();
    obs_t o, e;
    logic [2:0] want;
    drive_cycle(1, 0, 0, 0);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++; $display("FAIL speed_start: got %h want %h", o, e);
    end
    for (int k = 1; k <= 2048; k++) begin
      drive_cycle(1, 0, 0, 1);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL speed_walk[%0d]: got %h want %h", k, o, e);
      end
      if (k == 512 || k == 1536 || k == 2048) begin
`ifdef OBSTACLE_GEN_SPEEDUP_EN
        want = (k == 512) ? 3'd2 : 3'd4;
`else
        want = 3'd1;
`endif
        checks++;
        if (o.sp !== want) begin
          errors++;
          $display("FAIL speed_at_%0d: got %0d want %0d", k, o.sp, want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    #3 rst_n = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o.p1 !== 10'h3FF || o.p2 !== 10'h3FF || o.t1 !== 2'b00 ||
        o.t2 !== 2'b00 || o.sp !== 3'd1 || o.sg !== 1'b0 || o.c2 !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got %h want p=3ff/3ff t=0 spd=1 sp=0", o);
    end
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(0, 0, 0, 1);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++; $display("FAIL idle_ignores_tick: got %h want %h", o, e);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn();
    test_full_field();
    test_freeze();
    test_speed();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
